// File: rtl/cmd_dispatch_pkg.sv
// Shared constants for the command dispatcher: frame sync bytes, reply status
// codes, the broadcast wipe id and the FSM state encoding.
// Optional feature macro: CMD_DISPATCH_ECHO_EN (adds the REPLY2 echo state).
package cmd_dispatch_pkg;

  localparam logic [7:0] SYNC_CMD  = 8'hC0;
  localparam logic [7:0] SYNC_RESP = 8'hC1;
  localparam logic [7:0] WIPE_ID   = 8'hFF;

  localparam logic [7:0] ST_ACK        = 8'h01;
  localparam logic [7:0] ST_NAK        = 8'h02;
  localparam logic [7:0] ST_ERR        = 8'h03;
  localparam logic [7:0] ST_TIMEOUT    = 8'h04;
  localparam logic [7:0] ST_BAD_TARGET = 8'h05;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_WIPE    = 3'd4;
  localparam logic [2:0] S_REPLY   = 3'd5;
`ifdef CMD_DISPATCH_ECHO_EN
  localparam logic [2:0] S_REPLY2  = 3'd6;
`endif

  // Assemble a status reply word from its fields.
  function automatic logic [31:0] make_reply(input logic [7:0] status,
                                             input logic [7:0] tag,
                                             input logic [7:0] id);
    return {SYNC_RESP, status, tag, id};
  endfunction

endpackage

// File: rtl/dispatch_timeout_timer.sv
// Decoder response timeout timer. Cleared when a command is issued, counts
// while enabled, and flags expiry for one cycle on the (TIMEOUT_CYCLES-1)th
// enabled cycle so the wait state lasts TIMEOUT_CYCLES-1 cycles at most.
module dispatch_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count_q;

  assign expired_o = enable_i && (count_q == LAST);

  // Count enabled cycles; stop at the expiry value until cleared.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: takes header+payload frames from the host, strobes the
// addressed decoder, collects its ack/nak/err (or a timeout) and returns a
// status reply. Optional macro CMD_DISPATCH_ECHO_EN appends a second reply
// word echoing the payload.
module cmd_dispatcher
  import cmd_dispatch_pkg::*;
#(
  parameter int NUM_TARGETS    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [31:0]            received_data,
  output logic [NUM_TARGETS-1:0] data_valid,
  output logic                   wipe_settings,
  input  logic [NUM_TARGETS-1:0] dec_ack,
  input  logic [NUM_TARGETS-1:0] dec_nak,
  input  logic [NUM_TARGETS-1:0] dec_err,
  output logic [31:0]            resp_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [15:0]            sync_err_cnt
);

  localparam logic [7:0] NT_B = 8'(NUM_TARGETS);

  logic [2:0]             state_q, state_d;
  logic                   rx_ready_q;
  logic [31:0]            received_data_q;
  logic [NUM_TARGETS-1:0] data_valid_q;
  logic [NUM_TARGETS-1:0] target_mask_q;
  logic                   wipe_q;
  logic [31:0]            resp_data_q;
  logic                   resp_valid_q;
  logic [15:0]            sync_err_cnt_q;
  logic [7:0]             tag_q, id_q;
  logic [7:0]             status_d;

  logic rx_fire, resp_fire, hdr_ok;
  logic flag_ack, flag_nak, flag_err, timer_expired;

  assign rx_fire   = rx_valid && rx_ready_q;
  assign resp_fire = resp_valid_q && resp_ready;
  assign hdr_ok    = (rx_data[31:24] == SYNC_CMD);

  // Only the addressed decoder's flags are visible to the FSM.
  assign flag_ack = |(dec_ack & target_mask_q);
  assign flag_nak = |(dec_nak & target_mask_q);
  assign flag_err = |(dec_err & target_mask_q);

  dispatch_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (state_q == S_ISSUE),
    .enable_i (state_q == S_WAIT),
    .expired_o(timer_expired)
  );

  // Next state and the status captured on entry to REPLY.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a
    // missing branch infers a latch.
    state_d  = state_q;
    status_d = ST_ACK;
    case (state_q)
      S_IDLE: begin
        if (rx_fire && hdr_ok) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (rx_fire) begin
          if (id_q == WIPE_ID) begin
            state_d = S_WIPE;
          end else if (id_q >= NT_B) begin
            state_d  = S_REPLY;
            status_d = ST_BAD_TARGET;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (flag_err) begin
          state_d  = S_REPLY;
          status_d = ST_ERR;
        end else if (flag_nak) begin
          state_d  = S_REPLY;
          status_d = ST_NAK;
        end else if (flag_ack) begin
          state_d  = S_REPLY;
          status_d = ST_ACK;
        end else if (timer_expired) begin
          state_d  = S_REPLY;
          status_d = ST_TIMEOUT;
        end
      end
      S_WIPE: begin
        state_d  = S_REPLY;
        status_d = ST_ACK;
      end
      S_REPLY: begin
`ifdef CMD_DISPATCH_ECHO_EN
        if (resp_fire) state_d = S_REPLY2;
`else
        if (resp_fire) state_d = S_IDLE;
`endif
      end
`ifdef CMD_DISPATCH_ECHO_EN
      S_REPLY2: begin
        if (resp_fire) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, frame fields, strobes and the reply register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      rx_ready_q      <= 1'b0;
      received_data_q <= '0;
      data_valid_q    <= '0;
      target_mask_q   <= '0;
      wipe_q          <= 1'b0;
      resp_data_q     <= '0;
      resp_valid_q    <= 1'b0;
      sync_err_cnt_q  <= '0;
      tag_q           <= '0;
      id_q            <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == S_IDLE) || (state_d == S_PAYLOAD);
      wipe_q     <= (state_d == S_WIPE);

      // The strobe and the flag-select mask share the one-hot decode of id.
      data_valid_q <= '0;
      if (state_d == S_ISSUE) begin
        data_valid_q  <= NUM_TARGETS'(1) << id_q;
        target_mask_q <= NUM_TARGETS'(1) << id_q;
      end

      if (state_q == S_IDLE && rx_fire) begin
        if (hdr_ok) begin
          tag_q <= rx_data[15:8];
          id_q  <= rx_data[7:0];
        end else if (sync_err_cnt_q != 16'hFFFF) begin
          sync_err_cnt_q <= sync_err_cnt_q + 16'd1;
        end
      end

      // Held until the next payload: decoders sample it after their strobe.
      if (state_q == S_PAYLOAD && rx_fire) begin
        received_data_q <= rx_data;
      end

`ifdef CMD_DISPATCH_ECHO_EN
      resp_valid_q <= (state_d == S_REPLY) || (state_d == S_REPLY2);
      if (state_d == S_REPLY2 && state_q == S_REPLY) begin
        resp_data_q <= received_data_q;
      end
`else
      resp_valid_q <= (state_d == S_REPLY);
`endif
      if (state_d == S_REPLY && state_q != S_REPLY) begin
        resp_data_q <= make_reply(status_d, tag_q, id_q);
      end
    end
  end

  assign rx_ready      = rx_ready_q;
  assign received_data = received_data_q;
  assign data_valid    = data_valid_q;
  assign wipe_settings = wipe_q;
  assign resp_data     = resp_data_q;
  assign resp_valid    = resp_valid_q;
  assign sync_err_cnt  = sync_err_cnt_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher (NUM_TARGETS=8, TIMEOUT_CYCLES=1024).
// Build with CMD_DISPATCH_ECHO_EN defined to exercise the two-word reply.
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] received_data;
  logic [7:0]  data_valid;
  logic        wipe_settings;
  logic [7:0]  dec_ack, dec_nak, dec_err;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] sync_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cmd_dispatcher #(.NUM_TARGETS(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .received_data(received_data),
    .data_valid   (data_valid),
    .wipe_settings(wipe_settings),
    .dec_ack      (dec_ack),
    .dec_nak      (dec_nak),
    .dec_err      (dec_err),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .sync_err_cnt (sync_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns one cycle after the
  // transfer edge (the cycle in which data_valid should be up).
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    rx_data  = w;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      step();
      n++;
    end
    check("rx_ready_timeout", 32'(n < 50), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    dec_ack    = '0;
    dec_nak    = '0;
    dec_err    = '0;
    resp_ready = 1'b0;
    repeat (3) step();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_sync_cnt", 32'(sync_err_cnt), 32'd0);
    reset_n = 1'b1;
    step();

    // Ack from decoder 3, two cycles after its strobe.
    send_word(32'hC000_2A03);
    send_word(32'h0000_1234);
    check("t1_data_valid", 32'(data_valid), 32'h08);
    check("t1_received", received_data, 32'h0000_1234);
    step();
    check("t1_dv_one_cycle", 32'(data_valid), 32'h00);
    step();
    dec_ack = 8'h08;
    check("t1_no_early_resp", 32'(resp_valid), 32'd0);
    step();
    dec_ack = 8'h00;
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_data", resp_data, 32'hC101_2A03);
    check("t1_rx_ready_low", 32'(rx_ready), 32'd0);
    take_resp();
    check("t1_resp_drop", 32'(resp_valid), 32'd0);
    check("t1_received_hold", received_data, 32'h0000_1234);

    // Bad sync is dropped and counted; then a nak from decoder 1.
    send_word(32'h5500_0001);
    step();
    check("t2_sync_cnt", 32'(sync_err_cnt), 32'd1);
    check("t2_no_resp", 32'(resp_valid), 32'd0);
    send_word(32'hC000_0001);
    send_word(32'h0000_0055);
    check("t2_data_valid", 32'(data_valid), 32'h02);
    step();
    dec_nak = 8'h02;
    step();
    dec_nak = 8'h00;
    check("t2_resp_data", resp_data, 32'hC102_0001);
    take_resp();

    // Out-of-range target.
    send_word(32'hC000_0709);
    send_word(32'h1111_2222);
    check("t3_no_dv", 32'(data_valid), 32'h00);
    wait_resp(10, n);
    check("t3_resp_valid", 32'(resp_valid), 32'd1);
    check("t3_resp_data", resp_data, 32'hC105_0709);
    take_resp();

    // Silent decoder 2: reply exactly TIMEOUT_CYCLES after the strobe.
    send_word(32'hC000_3302);
    send_word(32'h0000_0000);
    check("t4_data_valid", 32'(data_valid), 32'h04);
    wait_resp(2000, n);
    check("t4_timeout_latency", 32'(n), 32'd1024);
    check("t4_resp_data", resp_data, 32'hC104_3302);
    take_resp();

    // Ack on a non-addressed index is ignored.
    send_word(32'hC000_3402);
    send_word(32'h0000_0000);
    dec_ack = 8'h20;
    wait_resp(2000, n);
    dec_ack = 8'h00;
    check("t4b_latency", 32'(n), 32'd1024);
    check("t4b_resp_data", resp_data, 32'hC104_3402);
    take_resp();

    // err beats ack on the addressed index.
    send_word(32'hC000_4402);
    send_word(32'h0000_0000);
    step();
    dec_err = 8'h04;
    dec_ack = 8'h04;
    step();
    dec_err = 8'h00;
    dec_ack = 8'h00;
    check("t4c_resp_data", resp_data, 32'hC103_4402);
    take_resp();

    // Wipe broadcast with reply back-pressure.
    send_word(32'hC000_11FF);
    send_word(32'h0000_0000);
    check("t5_wipe_high", 32'(wipe_settings), 32'd1);
    check("t5_no_dv", 32'(data_valid), 32'h00);
    step();
    check("t5_wipe_low", 32'(wipe_settings), 32'd0);
    check("t5_resp_valid", 32'(resp_valid), 32'd1);
    check("t5_resp_data", resp_data, 32'hC101_11FF);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t5_hold_valid", 32'(resp_valid), 32'd1);
      check("t5_hold_data", resp_data, 32'hC101_11FF);
    end
    take_resp();
    check("t5_resp_drop", 32'(resp_valid), 32'd0);

    // Reset while waiting on decoder 3: everything clears, no reply appears.
    send_word(32'hC000_5503);
    send_word(32'hAAAA_5555);
    step();
    reset_n = 1'b0;
    step();
    check("t6_rx_ready", 32'(rx_ready), 32'd0);
    check("t6_received", received_data, 32'h0);
    check("t6_dv", 32'(data_valid), 32'h0);
    check("t6_wipe", 32'(wipe_settings), 32'd0);
    check("t6_resp_valid", 32'(resp_valid), 32'd0);
    check("t6_resp_data", resp_data, 32'h0);
    check("t6_sync_cnt", 32'(sync_err_cnt), 32'd0);
    reset_n = 1'b1;
    dec_ack = 8'h08;
    repeat (5) step();
    dec_ack = 8'h00;
    check("t6_no_reply", 32'(resp_valid), 32'd0);
    check("t6_idle_ready", 32'(rx_ready), 32'd1);

`ifdef CMD_DISPATCH_ECHO_EN
    // Two-word reply: status then the echoed payload.
    send_word(32'hC000_6601);
    send_word(32'hDEAD_BEEF);
    step();
    dec_ack = 8'h02;
    step();
    dec_ack = 8'h00;
    check("t7_word0", resp_data, 32'hC101_6601);
    take_resp();
    check("t7_word1_valid", 32'(resp_valid), 32'd1);
    check("t7_word1", resp_data, 32'hDEAD_BEEF);
    take_resp();
    check("t7_drop", 32'(resp_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Upstream stage for the per-parameter decoders.
- Accepts 32-bit command frames from the host link: one header word, then one payload word.
- Broadcasts the payload on a shared received_data bus and pulses data_valid for the addressed decoder only.
- Collects that decoder's ack/nak/err (or a timeout) and returns a one-word status reply to the host.

Parameters:
- NUM_TARGETS, 8: number of attached decoders; valid range 1..254.
- TIMEOUT_CYCLES, 1024: cycles to wait for a decoder response before reporting a timeout; minimum 4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- rx_data  in  32  host command word.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  dispatcher accepts rx_data; transfer occurs when rx_valid and rx_ready are both high.
- received_data  out  32  payload broadcast to all decoders.
- data_valid  out  NUM_TARGETS  one-hot, one-cycle strobe to the addressed decoder.
- wipe_settings  out  1  one-cycle broadcast wipe strobe.
- dec_ack  in  NUM_TARGETS  per-decoder ack.
- dec_nak  in  NUM_TARGETS  per-decoder nak.
- dec_err  in  NUM_TARGETS  per-decoder err.
- resp_data  out  32  status reply word.
- resp_valid  out  1  reply valid.
- resp_ready  in  1  host accepts reply.
- sync_err_cnt  out  16  count of dropped headers with bad sync byte; saturating.

Behaviour:
- Reset (reset_n low at a clk edge), including mid-operation:
  - State goes to IDLE.
  - Outputs cleared: rx_ready, data_valid, wipe_settings, resp_valid, resp_data, received_data, sync_err_cnt.
  - The in-flight command is discarded and no reply is sent.
- Header word fields: [31:24] sync = 8'hC0; [15:8] tag; [7:0] target id. Bits [23:16] are ignored.
- Reply word fields: [31:24] = 8'hC1; [23:16] status; [15:8] tag; [7:0] target id.
- Status codes: 01 ACK, 02 NAK, 03 ERR, 04 TIMEOUT, 05 BAD_TARGET.
- IDLE:
  - rx_ready = 1.
  - On transfer with a bad sync byte: drop the word, increment sync_err_cnt (saturates at 16'hFFFF), stay in IDLE.
  - On transfer with a good sync byte: latch tag and id, go to PAYLOAD.
- PAYLOAD:
  - rx_ready = 1.
  - On transfer: latch rx_data into received_data.
  - id == 8'hFF: go to WIPE.
  - id >= NUM_TARGETS: status = BAD_TARGET, go to REPLY.
  - Otherwise go to ISSUE.
  - The payload word is never sync-checked.
- ISSUE:
  - data_valid[id] = 1 for exactly this cycle.
  - Clear the timeout counter, go to WAIT.
  - data_valid is registered: it rises the cycle after the payload transfer.
- WAIT:
  - rx_ready = 0.
  - Only the flags at index id are sampled; flags from all other indices are ignored.
  - Priority when flags coincide: err > nak > ack. Capture the status, go to REPLY.
  - If TIMEOUT_CYCLES-1 cycles pass with no flag: status = TIMEOUT, go to REPLY.
- WIPE:
  - wipe_settings = 1 for one cycle.
  - status = ACK, go to REPLY. Decoders are not waited on, since they are held in wipe.
- REPLY:
  - resp_valid = 1; resp_data is stable until resp_ready.
  - On the resp_ready handshake: go to IDLE next cycle, resp_valid drops.
  - Back-pressure may be held indefinitely.
- received_data is held from payload latch until the next payload latch. Decoders sample it one cycle after data_valid, so the hold is mandatory.
- Decoder flags arriving outside WAIT are ignored (no queuing).
- Latency: payload transfer at cycle T → data_valid at T+1. A decoder acking at T+3 gives resp_valid at T+4.

Optional Feature:
- Macro: CMD_DISPATCH_ECHO_EN.
- Defined: REPLY becomes two words. Word 0 is the status word; word 1 echoes received_data. Each word needs its own resp_ready handshake; IDLE is entered after word 1.
- Undefined: single-word reply only.

Decomposition:
- Package cmd_dispatch_pkg holds:
  - SYNC_CMD = 8'hC0 and SYNC_RESP = 8'hC1.
  - Status code constants.
  - WIPE_ID = 8'hFF.
  - State encoding (IDLE, PAYLOAD, ISSUE, WAIT, WIPE, REPLY, plus REPLY2 under the echo macro).
- One sub-module, dispatch_timeout_timer: clear/enable inputs, parameter TIMEOUT_CYCLES, one-cycle expired output, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Header 32'hC000_2A03, payload 32'h0000_1234; decoder 3 acks 2 cycles after its strobe → data_valid = 8'b0000_1000 for 1 cycle, received_data = 32'h1234, resp_data = 32'hC101_2A03.
- Header 32'h5500_0001 → word dropped, sync_err_cnt = 1, no reply. Then a valid frame to id 1 with nak → resp_data = 32'hC102_0001.
- Header 32'hC000_0709 (id 9 ≥ 8), any payload → no data_valid, resp_data = 32'hC105_0709.
- Frame to id 2 with no decoder response → resp_data = 32'hC104_xx02 after TIMEOUT_CYCLES. Also: err and ack asserted together on index 2 → status 03. Also: ack on index 5 only while the target is 2 → ignored, status 04.
- Header 32'hC000_11FF → wipe_settings high 1 cycle, resp_data = 32'hC101_11FF; resp_ready held low 20 cycles → resp_data stable.
- reset_n low during WAIT → all outputs 0, no reply. Also with CMD_DISPATCH_ECHO_EN: ack frame, payload 32'hDEAD_BEEF → replies C101_tt_id then DEAD_BEEF.
